// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU fetch/decode path
package cpu_pkg;

    localparam int INSTR_W = 32;

    // Major opcode classes carried in the op field
    localparam logic [1:0] OP_CODE_DP  = 2'b00;
    localparam logic [1:0] OP_CODE_MEM = 2'b01;
    localparam logic [1:0] OP_CODE_B   = 2'b10;

    // Instruction field bit positions
    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// rtl/fetch_timeout_cnt.sv - wait-cycle counter that flags an imem ack timeout
module fetch_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // Count un-acked request cycles; clear wins so a new wait always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expired on the last allowed wait cycle so the owner can halt at its end
    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem req/ack, single-entry instruction buffer
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         cond,
    output logic [1:0]         op,
    output logic [5:0]         funct,
    output logic [3:0]         rd,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc_plus8,
    input  logic               pc_ctrl,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic               fetch_err
);

    fetch_state_t        state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [ADDR_W-1:0]   target_q, target_n;
    logic [INSTR_W-1:0]  instr_q, instr_n;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_n;
    logic                valid_q, valid_n;
    logic                req_q, req_n;
    logic                err_q, err_n;
    logic                cnt_inc, cnt_clear, expired;
    logic [ADDR_W-1:0]   tgt;

    // Redirect targets are always word aligned
    assign tgt = pc_target & ~ADDR_W'(3);

    // Acks only matter while a request is outstanding
    assign cnt_clear = (imem_ack && req_q) || (state_n != state);

    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .expired (expired)
    );

    // State, PC and instruction buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            target_q   <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            target_q   <= target_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            valid_q    <= valid_n;
            req_q      <= req_n;
            err_q      <= err_n;
        end
    end

    // Next-state logic; a FETCH cycle with req low is a one-cycle bubble before requesting
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        target_n   = target_q;
        instr_n    = instr_q;
        instr_pc_n = instr_pc_q;
        valid_n    = valid_q;
        req_n      = req_q;
        err_n      = err_q;
        cnt_inc    = 1'b0;
        unique case (state)
            ST_FETCH: begin
                if (!req_q) begin
                    req_n = 1'b1;
                    if (pc_ctrl) begin
                        pc_n = tgt;
                    end
                end else if (imem_ack) begin
                    req_n = 1'b0;
                    if (pc_ctrl) begin
                        pc_n = tgt;
                    end else begin
                        instr_n    = imem_rdata;
                        instr_pc_n = pc;
                        pc_n       = pc + ADDR_W'(4);
                        valid_n    = 1'b1;
                        state_n    = ST_ISSUE;
                    end
                end else if (pc_ctrl) begin
                    target_n = tgt;
                    state_n  = ST_DRAIN;
                end else if (expired) begin
                    err_n   = 1'b1;
                    req_n   = 1'b0;
                    state_n = ST_HALT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (pc_ctrl) begin
                    valid_n = 1'b0;
                    pc_n    = tgt;
                    req_n   = 1'b1;
                    state_n = ST_FETCH;
                end else if (instr_ready) begin
                    valid_n = 1'b0;
                    req_n   = 1'b1;
                    state_n = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    pc_n    = pc_ctrl ? tgt : target_q;
                    req_n   = 1'b0;
                    state_n = ST_FETCH;
                end else if (expired) begin
                    err_n   = 1'b1;
                    req_n   = 1'b0;
                    state_n = ST_HALT;
                end else begin
                    cnt_inc = 1'b1;
                    if (pc_ctrl) begin
                        target_n = tgt;
                    end
                end
            end
            ST_HALT: begin
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
            default: begin
                state_n = ST_HALT;
            end
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus8    = instr_pc_q + ADDR_W'(8);
    assign fetch_err   = err_q;
    assign cond        = instr_q[COND_HI:COND_LO];
    assign op          = instr_q[OP_HI:OP_LO];
    assign funct       = instr_q[FUNCT_HI:FUNCT_LO];
    assign rd          = instr_q[RD_HI:RD_LO];

endmodule
